// File: rtl/rf_pkg.sv
// Shared types and widths for the register-file write-back path.
package rf_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam logic [ADDR_W-1:0] R15_ADDR = 4'd15;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Small synchronous FIFO holding FPU results until they win the write port.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  wb_entry_t        entry_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output wb_entry_t        head_o,
  output logic             head_dup_o
);

  wb_entry_t        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Another queued entry behind the head targets the same register.
  always_comb begin
    head_dup_o = 1'b0;
    for (int k = 1; k < FIFO_DEPTH; k++) begin
      if ((CNT_W'(k) < count_q) &&
          (mem_q[rd_ptr_q + PTR_W'(k)].addr == mem_q[rd_ptr_q].addr))
        head_dup_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between the ALU and buffered FPU results.
// state  | meaning
// NORMAL | ALU has priority, FIFO head pops when ALU idle
// DRAIN  | FIFO head pops every cycle, ALU held off
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_addr,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 fpu_valid,
  output logic                 fpu_ready,
  input  logic [ADDR_W-1:0]    fpu_addr,
  input  logic [DATA_W-1:0]    fpu_data,
  input  logic                 fpu_issue,
  input  logic [ADDR_W-1:0]    fpu_issue_addr,
  output logic [2**ADDR_W-1:0] busy_mask,
  output logic                 rf_wr_en,
  output logic [ADDR_W-1:0]    rf_wr_addr,
  output logic [DATA_W-1:0]    rf_wr_data,
  output logic                 err_r15
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam int NREG  = 2**ADDR_W;

  wb_state_t        state_q, state_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic [NREG-1:0]  busy_q, busy_d;
  logic             rf_wr_en_q;
  logic [ADDR_W-1:0] rf_wr_addr_q;
  logic [DATA_W-1:0] rf_wr_data_q;
  logic             err_r15_q;

  logic             fifo_full, fifo_empty, head_dup;
  logic [CNT_W-1:0] fifo_count, cnt_nxt;
  wb_entry_t        fifo_head, sel_entry;
  logic             alu_fire, pop, push, sel_valid, sel_r15;

  assign alu_ready = (state_q == NORMAL) && !busy_q[alu_addr];
  assign alu_fire  = alu_valid && alu_ready;
  assign pop       = !fifo_empty && ((state_q == DRAIN) || !alu_fire);
  assign fpu_ready = !fifo_full || pop;
  assign push      = fpu_valid && fpu_ready;

  assign sel_valid = alu_fire || pop;
  assign sel_entry = alu_fire ? wb_entry_t'{addr: alu_addr, data: alu_data} : fifo_head;
  assign sel_r15   = sel_valid && (sel_entry.addr == R15_ADDR);
  assign cnt_nxt   = fifo_count + CNT_W'(push) - CNT_W'(pop);

  wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .entry_i    (wb_entry_t'{addr: fpu_addr, data: fpu_data}),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .head_o     (fifo_head),
    .head_dup_o (head_dup)
  );

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop)
      starve_d = '0;
    else if (alu_fire && (starve_q != STV_W'(STARVE_MAX)))
      starve_d = starve_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL: if ((cnt_nxt == CNT_W'(FIFO_DEPTH)) || (starve_d == STV_W'(STARVE_MAX)))
                state_d = DRAIN;
      DRAIN:  if (cnt_nxt == '0)
                state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  // A pending write to the same register keeps the bit; issue set wins over clear.
  always_comb begin
    busy_d = busy_q;
    if (pop && !head_dup && !(push && (fpu_addr == fifo_head.addr)))
      busy_d[fifo_head.addr] = 1'b0;
    if (fpu_issue)
      busy_d[fpu_issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= NORMAL;
      starve_q     <= '0;
      busy_q       <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
      err_r15_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      busy_q     <= busy_d;
      rf_wr_en_q <= sel_valid && !sel_r15;
      if (sel_valid && !sel_r15) begin
        rf_wr_addr_q <= sel_entry.addr;
        rf_wr_data_q <= sel_entry.data;
      end
      if (sel_r15) err_r15_q <= 1'b1;
    end
  end

  assign busy_mask  = busy_q;
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign err_r15    = err_r15_q;

endmodule
